// File: rtl/i2c_reg_slave.sv
// I2C register-pointer responder: pointer byte then data on writes, pointer-based reads.
// Register storage lives outside; this block issues write strobes and a read index.
//   state     | meaning
//   IDLE      | bus free or not addressed, waiting for START
//   ADDR      | shifting 7-bit address + R/W
//   ADDR_ACK  | driving ACK for a matched address
//   PTR       | shifting pointer byte
//   PTR_ACK   | driving ACK for pointer byte
//   WDATA     | shifting write data byte
//   WDATA_ACK | driving ACK for write data (write strobe issued on entry)
//   RDATA     | driving read byte MSB first
//   RDATA_ACK | sampling master ACK/NACK
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h58,
    parameter int         NUM_REGS   = 8,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl,
    inout  wire              sda,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy,
    output logic             debug_addr_match,
    output logic [3:0]       debug_state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic             scl_s1_q, scl_s2_q, scl_d_q;
    logic             sda_s1_q, sda_s2_q, sda_d_q;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] pointer_q, pointer_d;
    logic             rw_q, rw_d;
    logic             got_ack_q, got_ack_d;
    logic             sel_q, sel_d;
    logic             sda_oe_q, sda_oe_d;
    logic             wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    logic scl_rise, scl_fall, start_det, stop_det, byte_done, addr_hit;

    assign scl_rise  = scl_s2_q & ~scl_d_q;
    assign scl_fall  = ~scl_s2_q & scl_d_q;
    assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
    assign byte_done = scl_fall && (bit_cnt_q == 4'd8);
    assign addr_hit  = (shift_q[7:1] == SLAVE_ADDR);

    // Sync flops reset high so a released bus never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_d_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_d_q    <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            pointer_q  <= '0;
            rw_q       <= 1'b0;
            got_ack_q  <= 1'b0;
            sel_q      <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            scl_s1_q   <= scl;
            scl_s2_q   <= scl_s1_q;
            scl_d_q    <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
            sda_d_q    <= sda_s2_q;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            pointer_q  <= pointer_d;
            rw_q       <= rw_d;
            got_ack_q  <= got_ack_d;
            sel_q      <= sel_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                ADDR:      if (byte_done) state_d = addr_hit ? ADDR_ACK : IDLE;
                ADDR_ACK:  if (scl_fall) state_d = rw_q ? RDATA : PTR;
                PTR:       if (byte_done) state_d = PTR_ACK;
                PTR_ACK:   if (scl_fall) state_d = WDATA;
                WDATA:     if (byte_done) state_d = WDATA_ACK;
                WDATA_ACK: if (scl_fall) state_d = WDATA;
                RDATA:     if (byte_done) state_d = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda_s2_q) state_d = IDLE;
                    else if (scl_fall && got_ack_q) state_d = RDATA;
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pointer_d  = pointer_q;
        rw_d       = rw_q;
        got_ack_d  = got_ack_q;
        sel_d      = sel_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (stop_det) begin
            sda_oe_d  = 1'b0;
            sel_d     = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            sel_d    = addr_hit;
                            sda_oe_d = addr_hit;
                            rw_d     = shift_q[0];
                        end else if (state_q == PTR) begin
                            sda_oe_d  = 1'b1;
                            pointer_d = shift_q[PTR_W-1:0];
                        end else begin
                            sda_oe_d   = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = pointer_q;
                            wr_data_d  = shift_q;
                            pointer_d  = pointer_q + 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            shift_d   = rd_data;
                            sda_oe_d  = ~rd_data[7];
                            got_ack_d = 1'b0;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        got_ack_d = 1'b0;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    // Pointer moves on the ACK rise so rd_data is settled by the next fall.
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            sel_d = 1'b0;
                        end else begin
                            pointer_d = pointer_q + 1'b1;
                            got_ack_d = 1'b1;
                        end
                    end else if (scl_fall && got_ack_q) begin
                        shift_d   = rd_data;
                        sda_oe_d  = ~rd_data[7];
                        got_ack_d = 1'b0;
                    end
                end
                default: begin
                    sel_d = 1'b0;
                end
            endcase
        end
    end

    assign sda              = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid         = wr_valid_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign rd_addr          = pointer_q;
    assign busy             = sel_q;
    assign debug_addr_match = sel_q;
    assign debug_state      = state_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged master, static register file model.
module tb_i2c_reg_slave;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       m_oe;
    wire        sda_w;
    logic       wr_valid, busy, dbg_match;
    logic [2:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic [3:0] dbg_state;
    logic [7:0] regs [0:7];

    int checks = 0;
    int errors = 0;
    int glitches = 0;
    logic match_seen = 1'b0;
    logic [10:0] wr_log [$];
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_moe = 1'b0;

    always #5 clk = ~clk;

    pullup (sda_w);
    assign sda_w   = m_oe ? 1'b0 : 1'bz;
    assign rd_data = regs[rd_addr];

    i2c_reg_slave #(.SLAVE_ADDR(7'h58), .NUM_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda_w),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .debug_addr_match(dbg_match), .debug_state(dbg_state)
    );

    always @(posedge clk) begin
        if (rst_n && wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (dbg_match) match_seen = 1'b1;
    end

    // Slave-driven sda must hold still while scl is high.
    always @(negedge clk) begin
        if (rst_n && scl_m && prev_scl && !m_oe && !prev_moe && (sda_w !== prev_sda))
            glitches++;
        prev_scl = scl_m;
        prev_sda = sda_w;
        prev_moe = m_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_oe = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        m_oe = 1'b1; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        m_oe = 1'b0; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_oe = ~b; tick(Q);
        scl_m = 1'b1; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_oe = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q / 2);
        b = sda_w; tick(Q / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack_bit);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl_m = 1'b1; m_oe = 1'b0;
        tick(5);
        checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        checks++; if ({busy, dbg_match, wr_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, dbg_match, wr_valid}); end
        checks++; if ({wr_addr, wr_data, rd_addr} !== 14'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {wr_addr, wr_data, rd_addr}); end
        checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_w); end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_write(input string tag);
        logic a0, a1, a2, a3;
        wr_log.delete();
        i2c_start();
        write_byte(8'hB0, a0);
        write_byte(8'h02, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h3C, a3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_before_stop: got %b want 1", tag, busy); end
        i2c_stop();
        tick(2);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL %s_acks: got %b want 0000", tag, {a0, a1, a2, a3}); end
        checks++; if ({busy, dbg_state} !== 5'd0) begin errors++; $display("FAIL %s_after_stop: got busy %b state %0d want 0 0", tag, busy, dbg_state); end
        checks++; if (wr_log.size() !== 2) begin errors++; $display("FAIL %s_wr_count: got %0d want 2", tag, wr_log.size()); end
        else begin
            checks++; if (wr_log[0] !== {3'd2, 8'hA5}) begin errors++; $display("FAIL %s_wr0: got %h want %h", tag, wr_log[0], {3'd2, 8'hA5}); end
            checks++; if (wr_log[1] !== {3'd3, 8'h3C}) begin errors++; $display("FAIL %s_wr1: got %h want %h", tag, wr_log[1], {3'd3, 8'h3C}); end
        end
        checks++; if (rd_addr !== 3'd4) begin errors++; $display("FAIL %s_ptr: got %0d want 4", tag, rd_addr); end
    endtask

    task automatic test_read_no_ptr();
        logic a;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hB1, a);
        read_byte(d, 1'b1);
        checks++; if ({busy, dbg_state} !== 5'd0) begin errors++; $display("FAIL rnp_after_nack: got busy %b state %0d want 0 0", busy, dbg_state); end
        i2c_stop();
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rnp_addr_ack: got %b want 0", a); end
        checks++; if (d !== 8'h4D) begin errors++; $display("FAIL rnp_data: got %h want 4d", d); end
        checks++; if (rd_addr !== 3'd4) begin errors++; $display("FAIL rnp_ptr: got %0d want 4", rd_addr); end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        match_seen = 1'b0;
        wr_log.delete();
        i2c_start();
        write_byte(8'hAA, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL nomatch_ack: got %b want 1", a); end
        checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL nomatch_state: got %0d want 0", dbg_state); end
        i2c_stop();
        checks++; if (match_seen !== 1'b0) begin errors++; $display("FAIL nomatch_sel: got %b want 0", match_seen); end
        checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL nomatch_wr: got %0d want 0", wr_log.size()); end
    endtask

    task automatic test_read_wrap();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        wr_log.delete();
        i2c_start();
        write_byte(8'hB0, a0);
        write_byte(8'h07, a1);
        i2c_start();
        write_byte(8'hB1, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL wrap_release: got %b want 1", sda_w); end
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL wrap_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL wrap_d0: got %h want 11", d0); end
        checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL wrap_d1: got %h want 22", d1); end
        checks++; if (rd_addr !== 3'd0) begin errors++; $display("FAIL wrap_ptr: got %0d want 0", rd_addr); end
        checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL wrap_no_wr: got %0d want 0", wr_log.size()); end
    endtask

    task automatic test_ptr_modulo();
        logic a0, a1, a2;
        wr_log.delete();
        i2c_start();
        write_byte(8'hB0, a0);
        write_byte(8'h0A, a1);
        write_byte(8'h99, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL mod_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL mod_wr_count: got %0d want 1", wr_log.size()); end
        else begin
            checks++; if (wr_log[0] !== {3'd2, 8'h99}) begin errors++; $display("FAIL mod_wr0: got %h want %h", wr_log[0], {3'd2, 8'h99}); end
        end
        checks++; if (rd_addr !== 3'd3) begin errors++; $display("FAIL mod_ptr: got %0d want 3", rd_addr); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] addr_byte;
        addr_byte = 8'hB0;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_byte[i]);
        m_oe = 1'b0;
        tick(2);
        checks++; if (sda_w !== 1'b0) begin errors++; $display("FAIL rstmid_ack_drive: got %b want 0", sda_w); end
        checks++; if (dbg_state !== 4'd2) begin errors++; $display("FAIL rstmid_state: got %0d want 2", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_w !== 1'b1) begin errors++; $display("FAIL rstmid_sda: got %b want 1", sda_w); end
        checks++; if ({busy, dbg_match, wr_valid, dbg_state} !== 7'd0) begin errors++; $display("FAIL rstmid_flags: got %b want 0", {busy, dbg_match, wr_valid, dbg_state}); end
        checks++; if ({wr_addr, wr_data, rd_addr} !== 14'h0) begin errors++; $display("FAIL rstmid_regs: got %h want 0", {wr_addr, wr_data, rd_addr}); end
        tick(3);
        rst_n = 1'b1;
        tick(3);
        i2c_stop();
        test_write("rstmid_w");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h60 + 8'(i);
        regs[7] = 8'h11;
        regs[0] = 8'h22;
        regs[4] = 8'h4D;
        test_reset();
        test_write("w1");
        test_read_no_ptr();
        test_addr_mismatch();
        test_read_wrap();
        test_ptr_modulo();
        test_reset_mid();
        checks++; if (glitches !== 0) begin errors++; $display("FAIL sda_glitch: got %0d want 0", glitches); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
